// File: rtl/aes_pkg.sv
// Shared AES definitions for the cipher/decipher datapath stages.
//   NR          : number of AES-128 rounds
//   RoundLast   : NR as a round index
//   NumKeys     : entries in a round-key store (NR+1)
//   round_idx_t : 4-bit round index
//   key_t       : 128-bit round key {w0,w1,w2,w3}, w0 in [127:96]
//   key_byte()  : byte r of key word w_c, used to apply column-major keys to row-major state
package aes_pkg;

    localparam int unsigned NR      = 10;
    localparam int unsigned NumKeys = NR + 1;

    typedef logic [3:0]   round_idx_t;
    typedef logic [127:0] key_t;

    localparam round_idx_t RoundLast = round_idx_t'(NR);

    // Key words are columns; state registers are rows. Byte r of w_c sits at
    // [127 - 32c - 8r -: 8].
    function automatic logic [7:0] key_byte(input key_t key, input int row, input int col);
        return key[127 - 32 * col - 8 * row -: 8];
    endfunction

endpackage

// File: rtl/inv_add_round_key_if.sv
// Bus bundle for inv_add_round_key: round-key write port, input state stream,
// output state stream and status.
//   slave  : the inv_add_round_key side
//   master : the producer/consumer side (key expansion, upstream stage, InvMixColumns)
interface inv_add_round_key_if;
    import aes_pkg::*;

    // Round-key write port
    logic        KEY_WE;
    round_idx_t  KEY_IDX;
    key_t        KEY_DATA;
    logic        KEYS_OK;

    // Input beat
    logic        IN_VALID;
    logic        IN_READY;
    logic        IN_FIRST;
    logic [31:0] IN_S0;
    logic [31:0] IN_S1;
    logic [31:0] IN_S2;
    logic [31:0] IN_S3;

    // Output beat
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_S0;
    logic [31:0] OUT_S1;
    logic [31:0] OUT_S2;
    logic [31:0] OUT_S3;
    round_idx_t  OUT_ROUND;
    logic        OUT_MIX;
    logic        OUT_LAST;
    logic        ERR;

    modport slave (
        input  KEY_WE, KEY_IDX, KEY_DATA,
        output KEYS_OK,
        input  IN_VALID, IN_FIRST, IN_S0, IN_S1, IN_S2, IN_S3,
        output IN_READY,
        input  OUT_READY,
        output OUT_VALID, OUT_S0, OUT_S1, OUT_S2, OUT_S3, OUT_ROUND, OUT_MIX, OUT_LAST,
        output ERR
    );

    modport master (
        output KEY_WE, KEY_IDX, KEY_DATA,
        input  KEYS_OK,
        output IN_VALID, IN_FIRST, IN_S0, IN_S1, IN_S2, IN_S3,
        input  IN_READY,
        output OUT_READY,
        input  OUT_VALID, OUT_S0, OUT_S1, OUT_S2, OUT_S3, OUT_ROUND, OUT_MIX, OUT_LAST,
        input  ERR
    );

endinterface

// File: rtl/inv_add_round_key_round_key_store.sv
// round_key_store: NR+1 x 128-bit round-key register file.
//   clk_i, rst_i : clock, synchronous active-high reset (clears only the loaded mask)
//   we_i         : write strobe; writes with wr_idx_i > NR are ignored
//   wr_idx_i     : write index
//   wr_data_i    : round key to store
//   rd_idx_i     : combinational read index
//   rd_key_o     : key at rd_idx_i (zero for out-of-range index)
//   keys_ok_o    : every entry written since reset
module round_key_store
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       we_i,
    input  round_idx_t wr_idx_i,
    input  key_t       wr_data_i,
    input  round_idx_t rd_idx_i,
    output key_t       rd_key_o,
    output logic       keys_ok_o
);

    key_t               key_q [NumKeys];
    key_t               key_d [NumKeys];
    logic [NumKeys-1:0] loaded_q;
    logic [NumKeys-1:0] loaded_d;
    logic               wr_ok;

    assign wr_ok = we_i && (wr_idx_i <= RoundLast);

    always_comb begin
        key_d    = key_q;
        loaded_d = loaded_q;
        if (wr_ok) begin
            key_d[wr_idx_i]    = wr_data_i;
            loaded_d[wr_idx_i] = 1'b1;
        end
    end

    // Key contents are deliberately not reset; the cleared mask gates their use.
    always_ff @(posedge clk_i) begin
        key_q <= key_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            loaded_q <= '0;
        end else begin
            loaded_q <= loaded_d;
        end
    end

    // Read sees the pre-write value, so a beat accepted alongside a write uses the old key.
    assign rd_key_o  = (rd_idx_i <= RoundLast) ? key_q[rd_idx_i] : '0;
    assign keys_ok_o = &loaded_q;

endmodule

// File: rtl/inv_add_round_key.sv
// inv_add_round_key: decryption-path AddRoundKey stage (AES-128).
// XORs round key NR..0 into successive state beats of a block and tags each
// output beat with its round so the next stage knows whether to apply InvMixColumns.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : inv_add_round_key_if.slave (key write port, input stream, output stream, ERR)
// One-cycle registered latency; one beat per cycle while OUT_READY is high.
module inv_add_round_key
    import aes_pkg::*;
(
    input logic                CLK,
    input logic                RST,
    inv_add_round_key_if.slave bus
);

    round_idx_t       rd_idx;
    key_t             rd_key;
    logic             keys_ok;
    logic             in_ready;
    logic             accept;
    logic             discard;
    logic [3:0][31:0] in_rows;
    logic [3:0][31:0] xor_rows;

    logic             busy_q, busy_d;
    round_idx_t       rnd_q, rnd_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0][31:0] out_s_q, out_s_d;
    round_idx_t       out_round_q, out_round_d;

    round_key_store u_round_key_store (
        .clk_i     (CLK),
        .rst_i     (RST),
        .we_i      (bus.KEY_WE),
        .wr_idx_i  (bus.KEY_IDX),
        .wr_data_i (bus.KEY_DATA),
        .rd_idx_i  (rd_idx),
        .rd_key_o  (rd_key),
        .keys_ok_o (keys_ok)
    );

    assign in_ready = keys_ok && (!out_valid_q || bus.OUT_READY);
    assign accept   = bus.IN_VALID && in_ready;
    assign discard  = !bus.IN_FIRST && !busy_q;
    assign rd_idx   = bus.IN_FIRST ? RoundLast : rnd_q;

    assign in_rows[0] = bus.IN_S0;
    assign in_rows[1] = bus.IN_S1;
    assign in_rows[2] = bus.IN_S2;
    assign in_rows[3] = bus.IN_S3;

    // Transposed key application: row r, column c takes byte r of key word w_c.
    always_comb begin
        xor_rows = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                xor_rows[r][31 - 8 * c -: 8] = in_rows[r][31 - 8 * c -: 8]
                                               ^ key_byte(rd_key, r, c);
            end
        end
    end

    always_comb begin
        busy_d      = busy_q;
        rnd_d       = rnd_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_s_d     = out_s_q;
        out_round_d = out_round_q;

        if (out_valid_q && bus.OUT_READY) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (bus.IN_FIRST) begin
                // A FIRST beat always restarts; hitting one mid-block is flagged.
                busy_d = 1'b1;
                rnd_d  = RoundLast - 4'd1;
                if (busy_q) begin
                    err_d = 1'b1;
                end
            end else if (busy_q) begin
                if (rnd_q == 4'd0) begin
                    busy_d = 1'b0;
                end else begin
                    rnd_d = rnd_q - 4'd1;
                end
            end else begin
                err_d = 1'b1;
            end

            // Reload in the same cycle as an output transfer, so no bubble.
            if (!discard) begin
                out_valid_d = 1'b1;
                out_s_d     = xor_rows;
                out_round_d = rd_idx;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_q      <= 1'b0;
            rnd_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_s_q     <= '0;
            out_round_q <= '0;
        end else begin
            busy_q      <= busy_d;
            rnd_q       <= rnd_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_round_q <= out_round_d;
        end
    end

    assign bus.KEYS_OK   = keys_ok;
    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_S0    = out_s_q[0];
    assign bus.OUT_S1    = out_s_q[1];
    assign bus.OUT_S2    = out_s_q[2];
    assign bus.OUT_S3    = out_s_q[3];
    assign bus.OUT_ROUND = out_round_q;
    // Tags are qualified by OUT_VALID so both read 0 out of reset.
    assign bus.OUT_MIX   = out_valid_q && (out_round_q != 4'd0) && (out_round_q != RoundLast);
    assign bus.OUT_LAST  = out_valid_q && (out_round_q == 4'd0);
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_inv_add_round_key.sv
// Self-checking bench for inv_add_round_key: scoreboard of expected output beats
// filled by the driver and drained by an output monitor, plus per-scenario checks.
module tb_inv_add_round_key;
    import aes_pkg::*;

    typedef struct packed {
        logic [127:0] st;
        round_idx_t   rnd;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    inv_add_round_key_if bus ();

    inv_add_round_key dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int         errors = 0;
    int         checks = 0;
    int         popped = 0;
    exp_t       sb[$];
    exp_t       mon_e;
    key_t       keys[11];
    logic       m_busy = 1'b0;
    round_idx_t m_rnd  = 4'd0;

    // Row r of a column-major 16-byte state (byte i at [127-8i -: 8]).
    function automatic logic [31:0] row_of(input logic [127:0] st, input int r);
        return {st[127 - 8 * r -: 8], st[127 - 8 * (4 + r) -: 8],
                st[127 - 8 * (8 + r) -: 8], st[127 - 8 * (12 + r) -: 8]};
    endfunction

    function automatic logic [127:0] rows_of(input logic [127:0] st);
        return {row_of(st, 0), row_of(st, 1), row_of(st, 2), row_of(st, 3)};
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Output monitor: a transfer happens on the next rising edge.
    always @(negedge clk) begin
        if (!rst && bus.OUT_VALID && bus.OUT_READY) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got OUT_ROUND=%0d, expected no beat",
                         bus.OUT_ROUND);
            end else begin
                mon_e = sb.pop_front();
                popped++;
                if ({bus.OUT_S0, bus.OUT_S1, bus.OUT_S2, bus.OUT_S3} !== rows_of(mon_e.st)) begin
                    errors++;
                    $display("FAIL beat_data: got %h, expected %h",
                             {bus.OUT_S0, bus.OUT_S1, bus.OUT_S2, bus.OUT_S3},
                             rows_of(mon_e.st));
                end
                checks++;
                if (bus.OUT_ROUND !== mon_e.rnd) begin
                    errors++;
                    $display("FAIL beat_round: got %0d, expected %0d", bus.OUT_ROUND, mon_e.rnd);
                end
                checks++;
                if (bus.OUT_MIX !== (mon_e.rnd >= 4'd1 && mon_e.rnd <= 4'd9)) begin
                    errors++;
                    $display("FAIL beat_mix: got %b at round %0d", bus.OUT_MIX, mon_e.rnd);
                end
                checks++;
                if (bus.OUT_LAST !== (mon_e.rnd == 4'd0)) begin
                    errors++;
                    $display("FAIL beat_last: got %b at round %0d", bus.OUT_LAST, mon_e.rnd);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic write_key(input round_idx_t idx, input key_t data);
        bus.KEY_WE   = 1'b1;
        bus.KEY_IDX  = idx;
        bus.KEY_DATA = data;
        sync();
        bus.KEY_WE   = 1'b0;
    endtask

    // Drive one beat, wait (bounded) for acceptance and update the reference model.
    task automatic send_beat(input logic first, input logic [127:0] st);
        int         waited = 0;
        round_idx_t k;
        bus.IN_VALID = 1'b1;
        bus.IN_FIRST = first;
        bus.IN_S0    = row_of(st, 0);
        bus.IN_S1    = row_of(st, 1);
        bus.IN_S2    = row_of(st, 2);
        bus.IN_S3    = row_of(st, 3);
        @(negedge clk);
        while (!bus.IN_READY && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.IN_READY) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got IN_READY=0 for 100 cycles, expected 1");
        end else begin
            k = first ? 4'd10 : m_rnd;
            if (first || m_busy) begin
                sb.push_back('{st: st ^ keys[k], rnd: k});
            end
            if (first) begin
                m_busy = 1'b1;
                m_rnd  = 4'd9;
            end else if (m_busy) begin
                if (m_rnd == 4'd0) m_busy = 1'b0;
                else m_rnd = m_rnd - 4'd1;
            end
        end
        sync();
        bus.IN_VALID = 1'b0;
        bus.IN_FIRST = 1'b0;
    endtask

    task automatic drain_and_check(input string name);
        repeat (3) sync();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats outstanding, expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) sync();
        rst = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.OUT_VALID);
        end
        checks++;
        if ({bus.OUT_S0, bus.OUT_S1, bus.OUT_S2, bus.OUT_S3} !== 128'h0) begin
            errors++; $display("FAIL reset_out_s: got %h, expected 0",
                               {bus.OUT_S0, bus.OUT_S1, bus.OUT_S2, bus.OUT_S3});
        end
        checks++;
        if ({bus.OUT_ROUND, bus.OUT_MIX, bus.OUT_LAST, bus.ERR} !== 7'b0) begin
            errors++; $display("FAIL reset_tags: got round=%0d mix=%b last=%b err=%b, expected 0",
                               bus.OUT_ROUND, bus.OUT_MIX, bus.OUT_LAST, bus.ERR);
        end
        checks++;
        if (bus.KEYS_OK !== 1'b0 || bus.IN_READY !== 1'b0) begin
            errors++; $display("FAIL reset_ready: got keys_ok=%b in_ready=%b, expected 0 0",
                               bus.KEYS_OK, bus.IN_READY);
        end
    endtask

    task automatic load_keys(input string name);
        write_key(4'd15, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff);
        for (int i = 0; i < 10; i++) begin
            write_key(round_idx_t'(i), keys[i]);
        end
        checks++;
        if (bus.KEYS_OK !== 1'b0 || bus.IN_READY !== 1'b0) begin
            errors++; $display("FAIL %s_before_last: got keys_ok=%b in_ready=%b, expected 0 0",
                               name, bus.KEYS_OK, bus.IN_READY);
        end
        write_key(4'd10, keys[10]);
        checks++;
        if (bus.KEYS_OK !== 1'b1 || bus.IN_READY !== 1'b1) begin
            errors++; $display("FAIL %s_after_last: got keys_ok=%b in_ready=%b, expected 1 1",
                               name, bus.KEYS_OK, bus.IN_READY);
        end
    endtask

    task automatic test_load_gating();
        bus.OUT_READY = 1'b1;
        load_keys("load");
    endtask

    task automatic test_full_block();
        send_beat(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.OUT_S0 !== 32'h7a892b3d) begin
            errors++; $display("FAIL round10_s0: got valid=%b s0=%h, expected 1 7a892b3d",
                               bus.OUT_VALID, bus.OUT_S0);
        end
        checks++;
        if (bus.OUT_ROUND !== 4'd10 || bus.OUT_MIX !== 1'b0) begin
            errors++; $display("FAIL round10_tags: got round=%0d mix=%b, expected 10 0",
                               bus.OUT_ROUND, bus.OUT_MIX);
        end
        for (int i = 0; i < 9; i++) begin
            send_beat(1'b0, rand_state());
        end
        send_beat(1'b0, 128'h00102030405060708090a0b0c0d0e0f0);
        checks++;
        if ({bus.OUT_S0, bus.OUT_S1, bus.OUT_S2, bus.OUT_S3}
                !== 128'h004488cc_115599dd_2266aaee_3377bbff) begin
            errors++; $display("FAIL round0_state: got %h, expected 004488cc115599dd2266aaee3377bbff",
                               {bus.OUT_S0, bus.OUT_S1, bus.OUT_S2, bus.OUT_S3});
        end
        checks++;
        if (bus.OUT_ROUND !== 4'd0 || bus.OUT_LAST !== 1'b1 || bus.OUT_MIX !== 1'b0) begin
            errors++; $display("FAIL round0_tags: got round=%0d last=%b mix=%b, expected 0 1 0",
                               bus.OUT_ROUND, bus.OUT_LAST, bus.OUT_MIX);
        end
        checks++;
        if (bus.ERR !== 1'b0) begin
            errors++; $display("FAIL block_err: got %b, expected 0", bus.ERR);
        end
        drain_and_check("block");
    endtask

    task automatic test_backpressure();
        int           p0 = popped;
        logic [131:0] snap;
        send_beat(1'b1, rand_state());
        send_beat(1'b0, rand_state());
        send_beat(1'b0, rand_state());
        bus.OUT_READY = 1'b0;
        snap = {bus.OUT_S0, bus.OUT_S1, bus.OUT_S2, bus.OUT_S3, bus.OUT_ROUND};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0) begin
                errors++; $display("FAIL stall_handshake: got valid=%b in_ready=%b, expected 1 0",
                                   bus.OUT_VALID, bus.IN_READY);
            end
            checks++;
            if ({bus.OUT_S0, bus.OUT_S1, bus.OUT_S2, bus.OUT_S3, bus.OUT_ROUND} !== snap) begin
                errors++; $display("FAIL stall_stable: got %h, expected %h",
                                   {bus.OUT_S0, bus.OUT_S1, bus.OUT_S2, bus.OUT_S3, bus.OUT_ROUND},
                                   snap);
            end
        end
        sync();
        bus.OUT_READY = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(1'b0, rand_state());
        end
        drain_and_check("stall");
        checks++;
        if (popped - p0 != 11) begin
            errors++; $display("FAIL stall_count: got %0d beats, expected 11", popped - p0);
        end
    endtask

    task automatic test_protocol_errors();
        send_beat(1'b0, rand_state());
        sync();
        checks++;
        if (bus.ERR !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
            errors++; $display("FAIL idle_beat: got err=%b valid=%b, expected 1 0",
                               bus.ERR, bus.OUT_VALID);
        end
        send_beat(1'b1, rand_state());
        for (int i = 0; i < 4; i++) begin
            send_beat(1'b0, rand_state());
        end
        send_beat(1'b1, rand_state());
        checks++;
        if (bus.OUT_ROUND !== 4'd10 || bus.ERR !== 1'b1) begin
            errors++; $display("FAIL restart: got round=%0d err=%b, expected 10 1",
                               bus.OUT_ROUND, bus.ERR);
        end
        for (int i = 0; i < 10; i++) begin
            send_beat(1'b0, rand_state());
        end
        drain_and_check("restart");
    endtask

    task automatic test_reset_mid_block();
        bus.OUT_READY = 1'b0;
        send_beat(1'b1, rand_state());
        checks++;
        if (bus.OUT_VALID !== 1'b1) begin
            errors++; $display("FAIL held_valid: got %b, expected 1", bus.OUT_VALID);
        end
        rst = 1'b1;
        sync();
        rst = 1'b0;
        sb.delete();
        m_busy = 1'b0;
        m_rnd  = 4'd0;
        bus.OUT_READY = 1'b1;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.KEYS_OK !== 1'b0 || bus.IN_READY !== 1'b0) begin
            errors++; $display("FAIL midrst: got valid=%b keys_ok=%b in_ready=%b, expected 0 0 0",
                               bus.OUT_VALID, bus.KEYS_OK, bus.IN_READY);
        end
        checks++;
        if (bus.ERR !== 1'b0) begin
            errors++; $display("FAIL midrst_err: got %b, expected 0", bus.ERR);
        end
        load_keys("reload");
        send_beat(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        for (int i = 0; i < 10; i++) begin
            send_beat(1'b0, rand_state());
        end
        drain_and_check("reload");
    endtask

    initial begin
        keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        keys[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        keys[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        keys[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        keys[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        keys[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        keys[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        keys[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        keys[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        keys[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;

        bus.KEY_WE    = 1'b0;
        bus.KEY_IDX   = 4'd0;
        bus.KEY_DATA  = '0;
        bus.IN_VALID  = 1'b0;
        bus.IN_FIRST  = 1'b0;
        bus.IN_S0     = '0;
        bus.IN_S1     = '0;
        bus.IN_S2     = '0;
        bus.IN_S3     = '0;
        bus.OUT_READY = 1'b1;

        test_reset();
        test_load_gating();
        test_full_block();
        test_backpressure();
        test_protocol_errors();
        test_reset_mid_block();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
